// File: rtl/shift_sequencer_if.sv
// Requester/sequencer bundle for shift_sequencer: two parallel-word request
// channels in, serial bit stream and transaction status out.
interface shift_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack0;
  logic             ack1;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic             done_id;

  // Requester side: drives requests and words, observes the stream.
  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, ser_out, ser_valid, busy, done, done_id
  );

  // Sequencer side.
  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, ser_out, ser_valid, busy, done, done_id
  );
endinterface

// File: rtl/shift_sequencer.sv
// Round-robin sequencer feeding a serial shift chain MSB-first from two requesters.
// Define SHIFT_SEQUENCER_FLUSH_EN to build the zero-flush phase after each payload.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int FLUSH = 4
) (
  input  logic               clock,
  input  logic               clear,
  shift_sequencer_if.slave   bus
);

  localparam int CNT_MAX = (WIDTH > FLUSH) ? WIDTH : FLUSH;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
`ifdef SHIFT_SEQUENCER_FLUSH_EN
  localparam logic [CW-1:0] LAST_FLUSH = CW'(FLUSH - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef SHIFT_SEQUENCER_FLUSH_EN
    S_FLUSH = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;

  // Registered outputs and their next values.
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic ser_out_q, ser_out_d;
  logic ser_valid_q, ser_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic done_id_q, done_id_d;

  // Arbitration: a lone request wins; on contention the one not served last wins.
  logic             grant0, grant1;
  logic [WIDTH-1:0] grant_word;

  assign grant0     = bus.req0 && (!bus.req1 || last_grant_q);
  assign grant1     = bus.req1 && (!bus.req0 || !last_grant_q);
  assign grant_word = grant1 ? bus.data1 : bus.data0;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    ser_out_d    = 1'b0;
    ser_valid_d  = 1'b0;
    done_d       = 1'b0;
    done_id_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          state_d      = S_SHIFT;
          shreg_d      = grant_word;
          cnt_d        = '0;
          last_grant_d = grant1;
          ack0_d       = grant0;
          ack1_d       = grant1;
          // The MSB goes out in the same cycle as the ack.
          ser_out_d    = grant_word[WIDTH-1];
          ser_valid_d  = 1'b1;
        end
      end

      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
`ifdef SHIFT_SEQUENCER_FLUSH_EN
          state_d = S_FLUSH;
`else
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = last_grant_q;
`endif
        end else begin
          cnt_d       = cnt_q + CW'(1);
          ser_out_d   = shreg_q[WIDTH-2];
          ser_valid_d = 1'b1;
        end
      end

`ifdef SHIFT_SEQUENCER_FLUSH_EN
      S_FLUSH: begin
        if (cnt_q == LAST_FLUSH) begin
          cnt_d     = '0;
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = last_grant_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      ser_out_q    <= ser_out_d;
      ser_valid_q  <= ser_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;

  // Structural invariants of the output protocol.
  a_one_ack : assert property (@(posedge clock) disable iff (!clear)
    !(ack0_q && ack1_q));
  a_valid_busy : assert property (@(posedge clock) disable iff (!clear)
    ser_valid_q |-> busy_q);
  a_done_busy : assert property (@(posedge clock) disable iff (!clear)
    done_q |-> (busy_q && !ser_valid_q));

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: per-cycle compare against a
// transaction-level schedule model, plus directed literal checks.
module tb_shift_sequencer;

  localparam int W = 8;
  localparam int F = 4;
`ifdef SHIFT_SEQUENCER_FLUSH_EN
  localparam int FL = F;
`else
  localparam int FL = 0;
`endif
  localparam int PERIOD   = W + FL + 2;
`ifdef SHIFT_SEQUENCER_FLUSH_EN
  localparam int DONE_CYC = 13;
`else
  localparam int DONE_CYC = 9;
`endif

  typedef struct packed {
    logic ack0;
    logic ack1;
    logic ser_out;
    logic ser_valid;
    logic busy;
    logic done;
    logic done_id;
  } out_t;

  logic clock;
  logic clear;
  int   checks;
  int   errors;
  bit   chk_en;

  shift_sequencer_if #(.WIDTH(W)) bus ();

  shift_sequencer #(.WIDTH(W), .FLUSH(F)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream 4-stage chain: its output a carries ser_out four cycles later.
  logic [3:0] chain;
  always @(posedge clock or negedge clear) begin
    if (!clear) chain <= '0;
    else        chain <= {chain[2:0], bus.ser_out};
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.ack0      = bus.ack0;
    o.ack1      = bus.ack1;
    o.ser_out   = bus.ser_out;
    o.ser_valid = bus.ser_valid;
    o.busy      = bus.busy;
    o.done      = bus.done;
    o.done_id   = bus.done_id;
    return o;
  endfunction

  // Reference model: on each grant, schedule the whole word's output records.
  out_t         sched[$];
  out_t         cur;
  out_t         rec_m;
  bit           lg;
  bit           g0, g1;
  logic [W-1:0] word_m;

  always @(posedge clock or negedge clear) begin
    if (!clear) begin
      sched.delete();
      cur = '0;
      lg  = 1'b1;
    end else begin
      if (!cur.busy) begin
        g0 = bus.req0 && (!bus.req1 || lg);
        g1 = bus.req1 && (!bus.req0 || !lg);
        if (g0 || g1) begin
          word_m = g1 ? bus.data1 : bus.data0;
          lg     = g1;
          for (int c = 1; c <= W + FL + 1; c++) begin
            rec_m      = '0;
            rec_m.busy = 1'b1;
            if (c == 1) begin
              rec_m.ack0 = g0;
              rec_m.ack1 = g1;
            end
            if (c <= W) begin
              rec_m.ser_valid = 1'b1;
              rec_m.ser_out   = word_m[W-c];
            end
            if (c == W + FL + 1) begin
              rec_m.done    = 1'b1;
              rec_m.done_id = g1;
            end
            sched.push_back(rec_m);
          end
        end
      end
      cur = (sched.size() != 0) ? sched.pop_front() : out_t'('0);
    end
  end

  always @(negedge clock) begin
    if (chk_en) check("cycle_outputs", 32'(sample()), 32'(cur));
  end

  // Directed capture: records cycles 1..n after the grant edge.
  out_t rec [1:16];
  logic ach [1:16];

  task automatic run_word(input bit who, input logic [W-1:0] word, input int n, input bit inject);
    if (who) begin bus.req1 = 1'b1; bus.data1 = word; end
    else     begin bus.req0 = 1'b1; bus.data0 = word; end
    for (int i = 1; i <= n; i++) begin
      @(negedge clock);
      rec[i] = sample();
      ach[i] = chain[3];
      if (i == 1) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      if (inject && i == 3) begin bus.req1 = 1'b1; bus.data1 = 8'hEE; end
      if (inject && i == 5) bus.req1 = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] stream(input int lo);
    logic [W-1:0] v = '0;
    for (int i = lo; i < lo + W; i++) v = {v[W-2:0], rec[i].ser_out};
    return v;
  endfunction

  function automatic logic [W-1:0] chain_stream(input int lo);
    logic [W-1:0] v = '0;
    for (int i = lo; i < lo + W; i++) v = {v[W-2:0], ach[i]};
    return v;
  endfunction

  function automatic int first_done(input int n);
    for (int i = 1; i <= n; i++) if (rec[i].done) return i;
    return 0;
  endfunction

  function automatic int count_ack1(input int n);
    int k = 0;
    for (int i = 1; i <= n; i++) if (rec[i].ack1) k++;
    return k;
  endfunction

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clock);
      if (!bus.busy) begin ok = 1'b1; break; end
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  int           ackc [0:3];
  int           nack, ndone;
  logic [3:0]   dseq;
  logic [3:0]   aseq;
  logic [31:0]  cstream;
  logic         valid_mask;

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.data0 = '0;  bus.data1 = '0;
    clear = 1'b1;
    #1 clear = 1'b0;
    chk_en = 1'b1;

    // Reset with both requests pending.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 8'h11; bus.data1 = 8'h22;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'(sample()), 32'd0);
    clear = 1'b1;
    @(negedge clock);
    check("reset_first_ack0", 32'(bus.ack0), 32'd1);
    check("reset_first_ack1", 32'(bus.ack1), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();

    // Single word from requester 0.
    run_word(1'b0, 8'hA5, 14, 1'b0);
    check("a5_ack0", 32'(rec[1].ack0), 32'd1);
    check("a5_stream", 32'(stream(1)), 32'hA5);
    valid_mask = 1'b1;
    for (int i = 1; i <= W; i++) valid_mask &= rec[i].ser_valid;
    check("a5_valid", 32'(valid_mask), 32'd1);
    check("a5_done_cycle", 32'(first_done(14)), 32'(DONE_CYC));
    check("a5_done_id", 32'(rec[DONE_CYC].done_id), 32'd0);
    check("a5_chain", 32'(chain_stream(5)), 32'hA5);
    check("a5_idle_after", 32'(rec[DONE_CYC+1].busy), 32'd0);
    wait_idle();

    // Request from requester 1 raised and dropped while busy is ignored.
    run_word(1'b0, 8'h5A, 14, 1'b1);
    check("ign_no_ack1", 32'(count_ack1(14)), 32'd0);
    check("ign_stream", 32'(stream(1)), 32'h5A);
    check("ign_done_cycle", 32'(first_done(14)), 32'(DONE_CYC));
    check("ign_done_id", 32'(rec[DONE_CYC].done_id), 32'd0);
    wait_idle();

    // Requester 1 alone.
    run_word(1'b1, 8'h81, 14, 1'b0);
    check("w81_ack1", 32'(rec[1].ack1), 32'd1);
    check("w81_stream", 32'(stream(1)), 32'h81);
    check("w81_done_cycle", 32'(first_done(14)), 32'(DONE_CYC));
    check("w81_done_id", 32'(rec[DONE_CYC].done_id), 32'd1);
    check("w81_idle_after", 32'(rec[DONE_CYC+1].busy), 32'd0);
    wait_idle();

    // Abort mid-payload with an asynchronous clear.
    bus.req0 = 1'b1; bus.data0 = 8'hFF;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (i == 1) bus.req0 = 1'b0;
    end
    check("abort_pre_valid", 32'(bus.ser_valid), 32'd1);
    #2 clear = 1'b0;
    #1;
    check("abort_ser_out", 32'(bus.ser_out), 32'd0);
    check("abort_ser_valid", 32'(bus.ser_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    clear = 1'b1;
    run_word(1'b1, 8'h3C, 14, 1'b0);
    check("post_abort_ack1", 32'(rec[1].ack1), 32'd1);
    check("post_abort_stream", 32'(stream(1)), 32'h3C);
    check("post_abort_done_id", 32'(rec[DONE_CYC].done_id), 32'd1);
    wait_idle();

    // Continuous contention: grants alternate starting with requester 0.
    bus.req0 = 1'b1; bus.data0 = 8'h0F;
    bus.req1 = 1'b1; bus.data1 = 8'hF0;
    nack = 0; ndone = 0; dseq = '0; aseq = '0; cstream = '0;
    for (int c = 1; c <= 4 * PERIOD; c++) begin
      @(negedge clock);
      if ((bus.ack0 || bus.ack1) && nack < 4) begin
        ackc[nack] = c;
        aseq = {aseq[2:0], bus.ack1};
        nack++;
      end
      if (bus.ser_valid) cstream = {cstream[30:0], bus.ser_out};
      if (bus.done) begin
        dseq = {dseq[2:0], bus.done_id};
        ndone++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check("cont_n_acks", 32'(nack), 32'd4);
    check("cont_n_done", 32'(ndone), 32'd4);
    check("cont_grant_seq", 32'(aseq), 32'b0101);
    check("cont_done_seq", 32'(dseq), 32'b0101);
    check("cont_streams", cstream, 32'h0FF00FF0);
    check("cont_first_ack", 32'(ackc[0]), 32'd1);
    check("cont_spacing", 32'(ackc[3] - ackc[0]), 32'(3 * PERIOD));
    wait_idle();

    // Randomized traffic with occasional asynchronous clears.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      if (!clear) clear = 1'b1;
      else if ($urandom_range(0, 199) == 0) begin
        #($urandom_range(1, 3)) clear = 1'b0;
      end
      bus.req0  = ($urandom_range(0, 2) != 0);
      bus.req1  = ($urandom_range(0, 2) != 0);
      bus.data0 = W'($urandom);
      bus.data1 = W'($urandom);
    end
    @(negedge clock);
    clear = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
